// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared types and timing helpers for the alarm buzzer block.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    localparam int DATA_W  = 16;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } alarm_state_t;

    // Clock cycles per half period of the buzzer square wave.
    function automatic int tone_half(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

    // Clock cycles per tone-on / tone-off beat phase.
    function automatic int beat_cyc(input int clk_hz, input int beat_ms);
        return clk_hz / 1000 * beat_ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buzzer_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_tone_gen
// Description : Square-wave tone divider gated by an on/off beat cadence.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_tone_gen #(
    parameter int TONE_HALF = 5,
    parameter int BEAT_CYC  = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tone_gated
);

    localparam int c_TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int c_BEAT_W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam logic [c_TONE_W-1:0] c_TONE_LAST = c_TONE_W'(TONE_HALF - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BEAT_CYC - 1);

    logic [c_TONE_W-1:0] r_tone_cnt, w_tone_cnt_nxt;
    logic [c_BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic                r_tone, w_tone_nxt;
    logic                r_beat_on, w_beat_on_nxt;

    always_comb begin
        w_tone_cnt_nxt = r_tone_cnt;
        w_beat_cnt_nxt = r_beat_cnt;
        w_tone_nxt     = r_tone;
        w_beat_on_nxt  = r_beat_on;
        if (restart) begin
            w_tone_cnt_nxt = '0;
            w_beat_cnt_nxt = '0;
            w_tone_nxt     = 1'b1;
            w_beat_on_nxt  = 1'b1;
        end else if (enable) begin
            if (r_tone_cnt == c_TONE_LAST) begin
                w_tone_cnt_nxt = '0;
                w_tone_nxt     = ~r_tone;
            end else begin
                w_tone_cnt_nxt = r_tone_cnt + c_TONE_W'(1);
            end
            if (r_beat_cnt == c_BEAT_LAST) begin
                w_beat_cnt_nxt = '0;
                w_beat_on_nxt  = ~r_beat_on;
            end else begin
                w_beat_cnt_nxt = r_beat_cnt + c_BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tone_cnt <= '0;
            r_beat_cnt <= '0;
            r_tone     <= 1'b0;
            r_beat_on  <= 1'b0;
        end else begin
            r_tone_cnt <= w_tone_cnt_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_tone     <= w_tone_nxt;
            r_beat_on  <= w_beat_on_nxt;
        end
    end

    // Gate value for the coming cycle, so the parent can register it in step.
    assign tone_gated = w_tone_nxt & w_beat_on_nxt;

endmodule
`default_nettype wire

// File: rtl/alarm_buzzer_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_buzzer_controller
// Description : Threshold/persistence alarm FSM with hysteresis, mute and
//               beat-gated buzzer tone.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_buzzer_controller
    import alarm_pkg::*;
#(
    parameter int                CLK_HZ  = 50000000,
    parameter int                TONE_HZ = 2000,
    parameter int                BEAT_MS = 250,
    parameter int                PERSIST = 4,
    parameter logic [DATA_W-1:0] HYST    = 16'd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  selected_data,
    input  logic [DATA_W-1:0]  threshold,
    input  logic               mute_req,
    output logic               buzzer,
    output logic               alarm_active,
    output logic               muted,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int c_TONE_HALF = tone_half(CLK_HZ, TONE_HZ);
    localparam int c_BEAT_CYC  = beat_cyc(CLK_HZ, BEAT_MS);
    localparam int c_CNT_W     = (PERSIST > 1) ? $clog2(PERSIST) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERSIST - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    alarm_state_t        r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_muted, w_muted_nxt;
    logic                r_buzzer;
    logic [DATA_W-1:0]   w_thr_lo;
    logic                w_above, w_below;
    logic                w_active_nxt, w_restart, w_tone_gated;

    // Saturating low threshold: with threshold < HYST nothing is ever below.
    assign w_thr_lo = (threshold >= HYST) ? (threshold - HYST) : '0;
    assign w_above  = (selected_data >= threshold);
    assign w_below  = (selected_data < w_thr_lo);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (sample_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_above) begin
                        if (PERSIST == 1) begin
                            w_state_nxt = ALARM;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ARMING;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                ARMING: begin
                    if (!w_above) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ALARM;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                ALARM: begin
                    w_cnt_nxt = '0;
                    if (w_below) begin
                        if (PERSIST == 1) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = CLEARING;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                CLEARING: begin
                    if (!w_below) begin
                        w_state_nxt = ALARM;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign alarm_active = (r_state == ALARM) || (r_state == CLEARING);
    assign w_active_nxt = (w_state_nxt == ALARM) || (w_state_nxt == CLEARING);
    // Only a fresh alarm restarts the cadence; CLEARING -> ALARM keeps it running.
    assign w_restart    = w_active_nxt & ~alarm_active;
    assign w_muted_nxt  = (w_state_nxt == IDLE) ? 1'b0 : (r_muted | (mute_req & alarm_active));

    buzzer_tone_gen #(
        .TONE_HALF (c_TONE_HALF),
        .BEAT_CYC  (c_BEAT_CYC)
    ) u_tone_gen (
        .clk        (clk),
        .reset      (reset),
        .enable     (alarm_active),
        .restart    (w_restart),
        .tone_gated (w_tone_gated)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_muted  <= 1'b0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_muted  <= w_muted_nxt;
            r_buzzer <= w_active_nxt & w_tone_gated & ~w_muted_nxt;
        end
    end

    assign buzzer    = r_buzzer;
    assign muted     = r_muted;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_buzzer_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_buzzer_controller
// Description : Directed and randomized checks against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_buzzer_controller;

    localparam int          CLK_HZ    = 1000;
    localparam int          TONE_HZ   = 100;
    localparam int          BEAT_MS   = 20;
    localparam int          PERSIST   = 3;
    localparam logic [15:0] HYST      = 16'd1;
    localparam int          TONE_HALF = 5;   // 1000 / (2*100)
    localparam int          BEAT_CYC  = 20;  // 1000 / 1000 * 20

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] selected_data;
    logic [15:0] threshold;
    logic        mute_req;
    logic        buzzer;
    logic        alarm_active;
    logic        muted;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // Model: alarm on/off, run length of qualifying samples, time since alarm start.
    bit m_alarm;
    int m_run;
    int m_t;
    bit m_muted;

    always #5 clk = ~clk;

    alarm_buzzer_controller #(
        .CLK_HZ  (CLK_HZ),
        .TONE_HZ (TONE_HZ),
        .BEAT_MS (BEAT_MS),
        .PERSIST (PERSIST),
        .HYST    (HYST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .selected_data (selected_data),
        .threshold     (threshold),
        .mute_req      (mute_req),
        .buzzer        (buzzer),
        .alarm_active  (alarm_active),
        .muted         (muted),
        .state_dbg     (state_dbg)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_alarm = 1'b0;
        m_run   = 0;
        m_t     = 0;
        m_muted = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input logic [15:0] thr, input bit m);
        bit was;
        bit qual;
        int lo;
        was = m_alarm;
        if (v) begin
            lo   = (int'(thr) >= int'(HYST)) ? int'(thr) - int'(HYST) : 0;
            qual = m_alarm ? (int'(d) < lo) : (d >= thr);
            if (qual) begin
                m_run++;
                if (m_run >= PERSIST) begin
                    m_alarm = !m_alarm;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        if (!m_alarm)     m_muted = 1'b0;
        else if (m && was) m_muted = 1'b1;
        if (!was && m_alarm) m_t = 0;
        else if (was)        m_t++;
    endtask

    function automatic logic [31:0] exp_buzzer();
        return {31'd0, m_alarm && !m_muted && ((m_t / TONE_HALF) % 2 == 0)
                       && ((m_t / BEAT_CYC) % 2 == 0)};
    endfunction

    function automatic logic [31:0] exp_state();
        return (m_alarm ? 2 : 0) + (m_run > 0 ? 1 : 0);
    endfunction

    task automatic check_outputs(input string tag);
        check_value({tag, ".buzzer"}, {31'd0, buzzer}, exp_buzzer());
        check_value({tag, ".active"}, {31'd0, alarm_active}, {31'd0, m_alarm});
        check_value({tag, ".muted"}, {31'd0, muted}, {31'd0, m_muted});
        check_value({tag, ".state"}, {30'd0, state_dbg}, exp_state());
    endtask

    // One clock: drive, let the edge happen, advance model, compare 1 time unit later.
    task automatic step(input bit v, input logic [15:0] d, input bit m, input string tag);
        sample_valid  = v;
        selected_data = d;
        mute_req      = m;
        @(posedge clk);
        model_step(v, d, threshold, m);
        #1;
        check_outputs(tag);
        sample_valid = 1'b0;
        mute_req     = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'b0, tag);
    endtask

    task automatic sample(input logic [15:0] d, input string tag);
        step(1'b1, d, 1'b0, tag);
        step(1'b0, 16'($urandom), 1'b0, tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("sync_reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called right after step(): reset lands between clock edges.
    task automatic async_reset_mid(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        sample_valid  = 1'b0;
        selected_data = '0;
        threshold     = 16'd5;
        mute_req      = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Arming and tone cadence
        sample(16'd5, "arm");
        sample(16'd6, "arm");
        sample(16'd7, "arm");
        idle(45, "tone");

        // Hysteresis: 4 is not below thr_lo=4, 3 is
        sample(16'd4, "hyst4"); sample(16'd4, "hyst4"); sample(16'd4, "hyst4");
        sample(16'd3, "clear"); sample(16'd3, "clear"); sample(16'd3, "clear");
        check_value("cleared", {31'd0, alarm_active}, 32'd0);

        // Interrupted arm, then a full arm
        sample(16'd5, "intr"); sample(16'd6, "intr"); sample(16'd4, "intr");
        check_value("intr_idle", {30'd0, state_dbg}, 32'd0);
        sample(16'd5, "rearm"); sample(16'd5, "rearm"); sample(16'd5, "rearm");
        idle(7, "rearm_tone");

        // Aborted clear returns to ALARM without restarting the cadence
        sample(16'd3, "abort"); sample(16'd3, "abort"); sample(16'd9, "abort");
        check_value("abort_alarm", {30'd0, state_dbg}, 32'd2);
        idle(12, "abort_tone");

        // Mute in alarm, clear, mute in idle
        step(1'b0, 16'd0, 1'b1, "mute");
        check_value("mute_set", {31'd0, muted}, 32'd1);
        idle(5, "muted");
        sample(16'd3, "mclr"); sample(16'd3, "mclr");
        step(1'b1, 16'd3, 1'b1, "mclr_coinc");
        step(1'b0, 16'd0, 1'b1, "mute_idle");
        check_value("mute_idle", {31'd0, muted}, 32'd0);

        // Async reset mid-alarm
        sample(16'd8, "pre_rst"); sample(16'd8, "pre_rst");
        step(1'b1, 16'd8, 1'b0, "pre_rst");
        check_value("pre_rst_buz", {31'd0, buzzer}, 32'd1);
        async_reset_mid("async_rst");

        // threshold = 0: arms on anything, never clears until threshold changes
        threshold = 16'd0;
        sample(16'd0, "thr0"); sample(16'd0, "thr0"); sample(16'd0, "thr0");
        for (int i = 0; i < 4; i++) sample(16'd0, "thr0_hold");
        threshold = 16'd5;
        sample(16'd3, "thr_chg"); sample(16'd3, "thr_chg"); sample(16'd3, "thr_chg");

        // threshold = FFFF: only FFFF arms; invalid cycles ignored
        threshold = 16'hFFFF;
        sample(16'hFFFE, "thrmax"); sample(16'hFFFE, "thrmax"); sample(16'hFFFE, "thrmax");
        for (int i = 0; i < 4; i++) step(1'b0, 16'hFFFF, 1'b0, "novalid");
        sample(16'hFFFF, "thrmax_arm"); sample(16'hFFFF, "thrmax_arm"); sample(16'hFFFF, "thrmax_arm");
        sample(16'd0, "thrmax_clr"); sample(16'd0, "thrmax_clr"); sample(16'd0, "thrmax_clr");

        // Randomized traffic
        threshold = 16'd5;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 5))
                    0:       threshold = 16'd0;
                    1:       threshold = 16'hFFFF;
                    default: threshold = 16'($urandom_range(1, 9));
                endcase
            end
            d = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
            step(1'($urandom_range(0, 1)), d, ($urandom_range(0, 39) == 0), "rand");
            if ($urandom_range(0, 499) == 0) async_reset_mid("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
